// File: rtl/axi_rd_burst_master_if.sv
// AXI3 read-channel bundle (AR + R) between the burst master and the memory slave.
interface axi_rd_burst_master_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 6
) ();
  logic [ID_W-1:0]   M_AXI_ARID;
  logic [31:0]       M_AXI_ARADDR;
  logic [3:0]        M_AXI_ARLEN;
  logic [2:0]        M_AXI_ARSIZE;
  logic [1:0]        M_AXI_ARBURST;
  logic              M_AXI_ARVALID;
  logic              M_AXI_ARREADY;
  logic [DATA_W-1:0] M_AXI_RDATA;
  logic [1:0]        M_AXI_RRESP;
  logic              M_AXI_RLAST;
  logic              M_AXI_RVALID;
  logic              M_AXI_RREADY;

  modport master (
    output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
           M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID
  );

  modport slave (
    input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
           M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID
  );
endinterface

// File: rtl/axi_rd_burst_master.sv
// Splits one read request into AXI3 INCR bursts and streams R beats into inBuf.
// Optional RD_PROTOCOL_CHECK_EN builds the per-burst RLAST/RRESP checker driving rd_error.
module axi_rd_burst_master #(
  parameter int unsigned C_M_AXI_DATA_WIDTH      = 64,
  parameter int unsigned C_M_AXI_RD_BURST_LEN    = 16,
  parameter int unsigned C_M_AXI_THREAD_ID_WIDTH = 6,
  parameter int unsigned TX_SIZE_WIDTH           = 10,
  parameter int unsigned MAX_OUTSTANDING         = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          rx_req,
  input  logic [31:0]                   rx_addr,
  input  logic [TX_SIZE_WIDTH-1:0]      rx_req_size,
  output logic                          rx_busy,
  output logic                          rx_done,
  output logic                          rd_complete,
  axi_rd_burst_master_if.master         m_axi,
  output logic [C_M_AXI_DATA_WIDTH-1:0] data_to_inBuf,
  output logic                          inBuf_push,
  input  logic                          inBuf_full,
  output logic                          rd_error
);

  localparam int unsigned BYTES       = C_M_AXI_DATA_WIDTH / 8;
  localparam int unsigned SIZE_LOG2   = $clog2(BYTES);
  localparam int unsigned BURST_BYTES = C_M_AXI_RD_BURST_LEN * BYTES;
  localparam int unsigned OUT_W       = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned BEAT_W      = $clog2(C_M_AXI_RD_BURST_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [31:0]              addr_q, addr_d;
  logic [3:0]               arlen_q, arlen_d;
  logic                     arvalid_q;
  logic [TX_SIZE_WIDTH-1:0] issue_rem_q, issue_d;
  logic [TX_SIZE_WIDTH-1:0] data_rem_q, data_d;
  logic [OUT_W-1:0]         out_q, out_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     cmpl_q, cmpl_d;
  logic [TX_SIZE_WIDTH-1:0] next_beats;

  logic                     rready_c;
  logic                     ar_hs;
  logic                     push;
  logic                     last_push;
  logic [TX_SIZE_WIDTH-1:0] burst_beats;

  // Data path is purely combinational: no added latency into inBuf.
  assign rready_c      = ~inBuf_full;
  assign ar_hs         = arvalid_q & m_axi.M_AXI_ARREADY;
  assign push          = m_axi.M_AXI_RVALID & rready_c & busy_q;
  assign last_push     = push & m_axi.M_AXI_RLAST;
  assign burst_beats   = (issue_rem_q > TX_SIZE_WIDTH'(C_M_AXI_RD_BURST_LEN))
                         ? TX_SIZE_WIDTH'(C_M_AXI_RD_BURST_LEN) : issue_rem_q;

  assign m_axi.M_AXI_RREADY  = rready_c;
  assign m_axi.M_AXI_ARID    = '0;
  assign m_axi.M_AXI_ARSIZE  = 3'(SIZE_LOG2);
  assign m_axi.M_AXI_ARBURST = 2'b01;
  assign m_axi.M_AXI_ARVALID = arvalid_q;
  assign m_axi.M_AXI_ARADDR  = addr_q;
  assign m_axi.M_AXI_ARLEN   = arlen_q;
  assign data_to_inBuf       = m_axi.M_AXI_RDATA;
  assign inBuf_push          = push;
  assign rx_busy             = busy_q;
  assign rx_done             = done_q;
  assign rd_complete         = cmpl_q;

  // Next-state, counter and registered-output values.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    issue_d    = issue_rem_q;
    data_d     = data_rem_q;
    out_d      = out_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cmpl_d     = 1'b0;
    next_beats = '0;
    arlen_d    = arlen_q;

    if (push) data_d = data_rem_q - TX_SIZE_WIDTH'(1);

    // An AR handshake and a burst-closing beat in the same cycle cancel out.
    if (ar_hs && !(last_push && out_q != '0))      out_d = out_q + OUT_W'(1);
    else if (!ar_hs && last_push && out_q != '0)  out_d = out_q - OUT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (rx_req) begin
          if (rx_req_size != '0) begin
            addr_d  = rx_addr;
            issue_d = rx_req_size;
            data_d  = rx_req_size;
            busy_d  = 1'b1;
            state_d = S_ISSUE;
          end else begin
            done_d = 1'b1;
            cmpl_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (ar_hs) begin
          addr_d  = addr_q + 32'(BURST_BYTES);
          issue_d = issue_rem_q - burst_beats;
          if (issue_d == '0) begin
            done_d  = 1'b1;
            state_d = S_DRAIN;
          end else if (out_d == OUT_W'(MAX_OUTSTANDING)) begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (out_d < OUT_W'(MAX_OUTSTANDING)) state_d = S_ISSUE;
      end
      S_DRAIN: begin
        if (data_d == '0) begin
          cmpl_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    next_beats = (issue_d > TX_SIZE_WIDTH'(C_M_AXI_RD_BURST_LEN))
                 ? TX_SIZE_WIDTH'(C_M_AXI_RD_BURST_LEN) : issue_d;
    if (state_d == S_ISSUE) arlen_d = 4'(next_beats - TX_SIZE_WIDTH'(1));
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      arlen_q     <= '0;
      arvalid_q   <= 1'b0;
      issue_rem_q <= '0;
      data_rem_q  <= '0;
      out_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmpl_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      arlen_q     <= arlen_d;
      arvalid_q   <= (state_d == S_ISSUE);
      issue_rem_q <= issue_d;
      data_rem_q  <= data_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmpl_q      <= cmpl_d;
    end
  end

`ifdef RD_PROTOCOL_CHECK_EN
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [BEAT_W-1:0] exp_beats [MAX_OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [OUT_W-1:0]  fill_q;
  logic [BEAT_W-1:0] beat_q;
  logic              err_q;
  logic              fifo_empty_c, fifo_push_c, fifo_pop_c, exp_last_c, err_set_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A burst closes on RLAST or on its expected final beat, whichever comes first.
  assign fifo_empty_c = (fill_q == '0);
  assign fifo_push_c  = ar_hs;
  assign exp_last_c   = ((beat_q + BEAT_W'(1)) == exp_beats[rd_ptr_q]);
  assign fifo_pop_c   = push & ~fifo_empty_c & (m_axi.M_AXI_RLAST | exp_last_c);
  assign err_set_c    = (push & ~fifo_empty_c & (m_axi.M_AXI_RLAST != exp_last_c))
                      | (push & (m_axi.M_AXI_RRESP != 2'b00))
                      | (m_axi.M_AXI_RVALID & busy_q & fifo_empty_c);

  always_ff @(posedge ACLK) begin
    if (fifo_push_c) exp_beats[wr_ptr_q] <= BEAT_W'(burst_beats);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      if (fifo_push_c) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (fifo_pop_c) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
        beat_q   <= '0;
      end else if (push && !fifo_empty_c) begin
        beat_q <= beat_q + BEAT_W'(1);
      end
      case ({fifo_push_c, fifo_pop_c})
        2'b10:   fill_q <= fill_q + OUT_W'(1);
        2'b01:   fill_q <= fill_q - OUT_W'(1);
        default: fill_q <= fill_q;
      endcase
      if (err_set_c) err_q <= 1'b1;
    end
  end

  assign rd_error = err_q;
`else
  logic unused_rresp;
  assign unused_rresp = ^m_axi.M_AXI_RRESP;
  assign rd_error     = 1'b0;
`endif

endmodule

// File: tb/tb_axi_rd_burst_master.sv
// Scoreboard bench for axi_rd_burst_master: directed requests against a simple AXI read slave.
module tb_axi_rd_burst_master;
  localparam int unsigned DW  = 64;
  localparam int unsigned IDW = 6;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic          rx_req;
  logic [31:0]   rx_addr;
  logic [9:0]    rx_req_size;
  logic          rx_busy, rx_done, rd_complete;
  logic [DW-1:0] data_to_inBuf;
  logic          inBuf_push;
  logic          inBuf_full;
  logic          rd_error;

  always #5 ACLK = ~ACLK;

  axi_rd_burst_master_if #(.DATA_W(DW), .ID_W(IDW)) axi ();

  axi_rd_burst_master dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .rx_req(rx_req), .rx_addr(rx_addr),
    .rx_req_size(rx_req_size), .rx_busy(rx_busy), .rx_done(rx_done),
    .rd_complete(rd_complete), .m_axi(axi), .data_to_inBuf(data_to_inBuf),
    .inBuf_push(inBuf_push), .inBuf_full(inBuf_full), .rd_error(rd_error)
  );

  int n_cmp = 0, n_err = 0;
  logic [35:0] exp_ar [$];
  logic [63:0] exp_data [$];
  logic [31:0] s_addr [$];
  logic [3:0]  s_len [$];

  bit ar_rand = 0, r_hold = 0, full_toggle = 0, chk_rready = 0;
  int rlast_inject = -1;
  int ar_cnt = 0, push_cnt = 0, done_cnt = 0, cmpl_cnt = 0;
  int ar_mark = -1, push_mark = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops expected AR / push values whenever the DUT presents one.
  initial begin
    logic [35:0] e;
    logic [63:0] d;
    forever begin
      @(negedge ACLK);
      if (axi.M_AXI_ARVALID && axi.M_AXI_ARREADY) begin
        ar_cnt++;
        if (ar_cnt == ar_mark) push_mark = push_cnt;
        n_cmp++;
        if (exp_ar.size() == 0) begin
          n_err++;
          $display("FAIL ar_unexpected: got AR addr 0x%0h len %0d with none expected",
                   axi.M_AXI_ARADDR, axi.M_AXI_ARLEN);
        end else begin
          e = exp_ar.pop_front();
          check("ar_addr", 64'(axi.M_AXI_ARADDR), 64'(e[35:4]));
          check("ar_len", 64'(axi.M_AXI_ARLEN), 64'(e[3:0]));
        end
      end
      if (inBuf_push) begin
        push_cnt++;
        n_cmp++;
        if (exp_data.size() == 0) begin
          n_err++;
          $display("FAIL push_unexpected: got data 0x%0h with none expected", data_to_inBuf);
        end else begin
          d = exp_data.pop_front();
          check("push_data", data_to_inBuf, d);
        end
      end
      if (rx_done) done_cnt++;
      if (rd_complete) cmpl_cnt++;
      if (chk_rready) check("rready_mirror", 64'(axi.M_AXI_RREADY), 64'(!inBuf_full));
    end
  end

  // AR slave: always ready, or ready after a random 1..15 cycle delay per burst.
  initial begin
    bit hs, prev;
    int ar_wait;
    prev = 0; ar_wait = 0;
    axi.M_AXI_ARREADY = 1'b0;
    forever begin
      @(negedge ACLK);
      hs = axi.M_AXI_ARVALID && axi.M_AXI_ARREADY;
      if (hs) begin
        s_addr.push_back(axi.M_AXI_ARADDR);
        s_len.push_back(axi.M_AXI_ARLEN);
      end
      @(posedge ACLK); #1;
      if (!ar_rand) begin
        axi.M_AXI_ARREADY = 1'b1; prev = 0;
      end else if (!prev || hs) begin
        prev = 1; axi.M_AXI_ARREADY = 1'b0; ar_wait = int'($urandom_range(15, 1));
      end else if (!axi.M_AXI_ARREADY) begin
        if (ar_wait > 1) ar_wait--;
        else axi.M_AXI_ARREADY = 1'b1;
      end
    end
  end

  // R slave: data for beat i of a burst at A is A/8 + i.
  initial begin
    bit rhs;
    int beat;
    beat = 0;
    axi.M_AXI_RVALID = 1'b0; axi.M_AXI_RDATA = '0; axi.M_AXI_RLAST = 1'b0; axi.M_AXI_RRESP = 2'b00;
    forever begin
      @(negedge ACLK);
      rhs = axi.M_AXI_RVALID && axi.M_AXI_RREADY;
      @(posedge ACLK); #1;
      if (rhs) begin
        if (beat == int'(s_len[0])) begin
          void'(s_addr.pop_front()); void'(s_len.pop_front()); beat = 0;
        end else beat++;
      end
      if (!r_hold && s_len.size() > 0) begin
        axi.M_AXI_RVALID = 1'b1;
        axi.M_AXI_RDATA  = 64'(s_addr[0] >> 3) + 64'(beat);
        axi.M_AXI_RLAST  = (beat == int'(s_len[0])) || (beat == rlast_inject);
      end else begin
        axi.M_AXI_RVALID = 1'b0;
        axi.M_AXI_RLAST  = 1'b0;
      end
    end
  end

  initial begin
    inBuf_full = 1'b0;
    forever begin
      @(posedge ACLK); #1;
      inBuf_full = full_toggle ? ~inBuf_full : 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic req(input logic [31:0] a, input logic [9:0] sz);
    rx_addr = a; rx_req_size = sz; rx_req = 1'b1;
    @(posedge ACLK); #1;
    rx_req = 1'b0;
  endtask

  task automatic exp_burst(input logic [31:0] a, input logic [3:0] len);
    exp_ar.push_back({a, len});
  endtask

  task automatic exp_beats(input logic [63:0] first, input int n);
    for (int i = 0; i < n; i++) exp_data.push_back(first + 64'(i));
  endtask

  task automatic wait_cmpl(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (cmpl_cnt < target && k < budget) begin
      @(posedge ACLK); #2; k++;
    end
    n_cmp++;
    if (cmpl_cnt < target) begin
      n_err++;
      $display("FAIL %s_timeout: got %0d completions expected %0d", name, cmpl_cnt, target);
    end
  endtask

  initial begin
    int c0, d0, p0, a0, k;
    rx_req = 1'b0; rx_addr = '0; rx_req_size = '0; ARESETN = 1'b0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_arvalid", 64'(axi.M_AXI_ARVALID), 64'(0));
    check("rst_araddr", 64'(axi.M_AXI_ARADDR), 64'(0));
    check("rst_arlen", 64'(axi.M_AXI_ARLEN), 64'(0));
    check("rst_arsize", 64'(axi.M_AXI_ARSIZE), 64'(3));
    check("rst_arburst", 64'(axi.M_AXI_ARBURST), 64'(1));
    check("rst_arid", 64'(axi.M_AXI_ARID), 64'(0));
    check("rst_busy", 64'(rx_busy), 64'(0));
    check("rst_done", 64'(rx_done), 64'(0));
    check("rst_cmpl", 64'(rd_complete), 64'(0));
    check("rst_err", 64'(rd_error), 64'(0));
    @(posedge ACLK); #1; ARESETN = 1'b1;
    repeat (2) @(posedge ACLK); #1;

    // Single 16-beat burst; a second request while busy must be ignored.
    c0 = cmpl_cnt; d0 = done_cnt; p0 = push_cnt;
    exp_burst(32'h1000, 4'd15); exp_beats(64'h200, 16);
    req(32'h1000, 10'd16);
    @(negedge ACLK); check("t1_busy", 64'(rx_busy), 64'(1));
    @(posedge ACLK); #1; req(32'h8000, 10'd16);
    wait_cmpl(c0 + 1, 500, "t1");
    repeat (5) @(posedge ACLK); #2;
    check("t1_busy_low", 64'(rx_busy), 64'(0));
    check("t1_done_pulses", 64'(done_cnt - d0), 64'(1));
    check("t1_cmpl_pulses", 64'(cmpl_cnt - c0), 64'(1));
    check("t1_pushes", 64'(push_cnt - p0), 64'(16));

    // 37 beats with random ARREADY delay: 16+16+5.
    c0 = cmpl_cnt; p0 = push_cnt; ar_rand = 1;
    exp_burst(32'h2000, 4'd15); exp_burst(32'h2080, 4'd15); exp_burst(32'h2100, 4'd4);
    exp_beats(64'h400, 37);
    req(32'h2000, 10'd37);
    wait_cmpl(c0 + 1, 2000, "t2");
    ar_rand = 0;
    repeat (3) @(posedge ACLK); #2;
    check("t2_pushes", 64'(push_cnt - p0), 64'(37));
    check("t2_ar_left", 64'(exp_ar.size()), 64'(0));

    // Outstanding limit: 4 ARs with R held off, 5th only after the first burst drains.
    c0 = cmpl_cnt; p0 = push_cnt; a0 = ar_cnt; r_hold = 1; ar_mark = a0 + 5;
    for (int b = 0; b < 10; b++) exp_burst(32'h3000 + 32'(b * 128), 4'd15);
    exp_beats(64'h600, 160);
    req(32'h3000, 10'd160);
    repeat (40) @(posedge ACLK); #2;
    check("t3_ar_at_limit", 64'(ar_cnt - a0), 64'(4));
    check("t3_arvalid_low", 64'(axi.M_AXI_ARVALID), 64'(0));
    r_hold = 0;
    wait_cmpl(c0 + 1, 2000, "t3");
    check("t3_fifth_ar_after_burst", 64'(push_mark - p0 >= 16), 64'(1));
    check("t3_pushes", 64'(push_cnt - p0), 64'(160));
    check("t3_ar_left", 64'(exp_ar.size()), 64'(0));

    // inBuf back-pressure toggling every cycle.
    c0 = cmpl_cnt; p0 = push_cnt; full_toggle = 1; chk_rready = 1;
    exp_burst(32'h0, 4'd15); exp_beats(64'h0, 16);
    req(32'h0, 10'd16);
    wait_cmpl(c0 + 1, 500, "t4");
    full_toggle = 0; chk_rready = 0;
    repeat (3) @(posedge ACLK); #2;
    check("t4_pushes", 64'(push_cnt - p0), 64'(16));
    check("t4_data_left", 64'(exp_data.size()), 64'(0));

    // Zero-size request: immediate done/complete, no AR.
    a0 = ar_cnt; @(posedge ACLK); #1;
    req(32'h4000, 10'd0);
    @(negedge ACLK);
    check("t5_done", 64'(rx_done), 64'(1));
    check("t5_cmpl", 64'(rd_complete), 64'(1));
    check("t5_busy", 64'(rx_busy), 64'(0));
    check("t5_arvalid", 64'(axi.M_AXI_ARVALID), 64'(0));
    @(negedge ACLK);
    check("t5_done_low", 64'(rx_done), 64'(0));
    check("t5_cmpl_low", 64'(rd_complete), 64'(0));
    check("t5_no_ar", 64'(ar_cnt - a0), 64'(0));

`ifdef RD_PROTOCOL_CHECK_EN
    // Early RLAST on the third beat sets the sticky error.
    @(posedge ACLK); #1;
    c0 = cmpl_cnt; rlast_inject = 2;
    exp_burst(32'h6000, 4'd15); exp_beats(64'hC00, 16);
    req(32'h6000, 10'd16);
    wait_cmpl(c0 + 1, 500, "t6");
    rlast_inject = -1;
    check("t6_err_set", 64'(rd_error), 64'(1));
    repeat (5) @(posedge ACLK); #2;
    check("t6_err_sticky", 64'(rd_error), 64'(1));
    ARESETN = 1'b0; @(posedge ACLK); #1; ARESETN = 1'b1;
    @(negedge ACLK);
    check("t6_err_cleared", 64'(rd_error), 64'(0));
`else
    check("t6_err_tied", 64'(rd_error), 64'(0));
`endif

    // Reset mid-transfer: no further AR, in-flight beats accepted but not pushed.
    @(posedge ACLK); #1;
    p0 = push_cnt;
    for (int b = 0; b < 6; b++) exp_burst(32'h7000 + 32'(b * 128), 4'd15);
    exp_beats(64'hE00, 96);
    req(32'h7000, 10'd96);
    k = 0;
    while (push_cnt - p0 < 5 && k < 200) begin @(posedge ACLK); #2; k++; end
    check("t7_started", 64'(push_cnt - p0 >= 5), 64'(1));
    ARESETN = 1'b0;
    @(posedge ACLK); #1;
    exp_ar.delete(); exp_data.delete();
    @(negedge ACLK);
    p0 = push_cnt; a0 = ar_cnt;
    check("t7_rst_arvalid", 64'(axi.M_AXI_ARVALID), 64'(0));
    check("t7_rst_araddr", 64'(axi.M_AXI_ARADDR), 64'(0));
    check("t7_rst_busy", 64'(rx_busy), 64'(0));
    check("t7_rst_push", 64'(inBuf_push), 64'(0));
    check("t7_rst_err", 64'(rd_error), 64'(0));
    @(posedge ACLK); #1; ARESETN = 1'b1;
    k = 0;
    while (s_len.size() > 0 && k < 300) begin @(posedge ACLK); #2; k++; end
    check("t7_inflight_drained", 64'(s_len.size()), 64'(0));
    check("t7_no_push", 64'(push_cnt - p0), 64'(0));
    check("t7_no_ar", 64'(ar_cnt - a0), 64'(0));
    check("t7_done_low", 64'(rx_done), 64'(0));

    repeat (3) @(posedge ACLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
